// File: rtl/vdec_hs_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : vdec_hs_fwd
//  Purpose  : Forward add-compare-select pass of a K=9, rate-1/3 Viterbi
//             decoder. Reads one soft symbol per trellis step, updates 256
//             path metrics (32 per cycle over 8 cycles) and writes the
//             survivor decisions to the pointer RAM for later traceback.
//  Revision : 1.0  initial release
// ============================================================================
module vdec_hs_fwd (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic [5:0]  codeblk_size_p7,
   output logic        sym_rd,
   output logic [5:0]  sym_addr,
   input  logic [17:0] sym_dout,
   output logic        pt_wr,
   output logic [8:0]  pt_addr,
   output logic [31:0] pt_din
);

   localparam logic [5:0]  C_L_MAX   = 6'd37;
   localparam logic [11:0] C_PM_INIT = 12'd3584;
   localparam logic [8:0]  C_G0      = 9'o557;
   localparam logic [8:0]  C_G1      = 9'o663;
   localparam logic [8:0]  C_G2      = 9'o711;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_BM   = 3'd2,
      S_ACS  = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [5:0]  r_len;
   logic [5:0]  r_step;
   logic [2:0]  r_word;
   logic [5:0]  r_sym_addr;
   logic [31:0] r_pt_din;
   logic        r_bank;
   logic [8:0]  r_bm [8];
   logic [11:0] r_pm [2][256];

   logic [5:0]  w_len;
   logic [8:0]  w_bm [8];
   logic [31:0] w_surv;
   logic [11:0] w_pm_new [32];

   // Trellis length is saturated at the largest supported block
   assign w_len    = (codeblk_size_p7 > C_L_MAX) ? C_L_MAX : codeblk_size_p7;
   assign sym_addr = r_sym_addr;
   assign pt_addr  = {r_step, r_word};

   // Next-state and strobe decode; pt_din shows live decisions during ACS
   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state != S_IDLE);
      done        = 1'b0;
      sym_rd      = 1'b0;
      pt_wr       = 1'b0;
      pt_din      = r_pt_din;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (w_len == 6'd0) ? S_FIN : S_RD;
            end
         end
         S_RD: begin
            sym_rd      = 1'b1;
            w_state_nxt = S_BM;
         end
         S_BM: begin
            w_state_nxt = S_ACS;
         end
         S_ACS: begin
            pt_wr  = 1'b1;
            pt_din = w_surv;
            if (r_word == 3'd7) begin
               w_state_nxt = (r_step < r_len) ? S_RD : S_FIN;
            end
         end
         S_FIN: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Eight branch metrics, indexed by the coded-bit pattern {c2,c1,c0}
   always_comb begin
      logic signed [8:0] w_l0;
      logic signed [8:0] w_l1;
      logic signed [8:0] w_l2;
      w_l0 = {{3{sym_dout[5]}},  sym_dout[5:0]};
      w_l1 = {{3{sym_dout[11]}}, sym_dout[11:6]};
      w_l2 = {{3{sym_dout[17]}}, sym_dout[17:12]};
      for (int c = 0; c < 8; c++) begin
         w_bm[c] = (((c & 1) != 0) ? -w_l0 : w_l0)
                 + (((c & 2) != 0) ? -w_l1 : w_l1)
                 + (((c & 4) != 0) ? -w_l2 : w_l2);
      end
   end

   // 32 parallel ACS units for states {r_word, b}
   always_comb begin
      logic [7:0]  w_s;
      logic [7:0]  w_p0;
      logic [7:0]  w_p1;
      logic [8:0]  w_win0;
      logic [8:0]  w_win1;
      logic [2:0]  w_c0;
      logic [2:0]  w_c1;
      logic [8:0]  w_b0;
      logic [8:0]  w_b1;
      logic [11:0] w_m0;
      logic [11:0] w_m1;
      logic [11:0] w_diff;
      logic        w_sel;
      w_surv = 32'd0;
      for (int b = 0; b < 32; b++) begin
         w_s    = {r_word, 5'(b)};
         w_p0   = {1'b0, w_s[7:1]};
         w_p1   = {1'b1, w_s[7:1]};
         w_win0 = {w_p0, w_s[0]};
         w_win1 = {w_p1, w_s[0]};
         w_c0   = {^(w_win0 & C_G2), ^(w_win0 & C_G1), ^(w_win0 & C_G0)};
         w_c1   = {^(w_win1 & C_G2), ^(w_win1 & C_G1), ^(w_win1 & C_G0)};
         w_b0   = r_bm[w_c0];
         w_b1   = r_bm[w_c1];
         w_m0   = r_pm[r_bank][w_p0] + {{3{w_b0[8]}}, w_b0};
         w_m1   = r_pm[r_bank][w_p1] + {{3{w_b1[8]}}, w_b1};
         // Modular compare: p1 wins only on a strictly positive difference
         w_diff = w_m1 - w_m0;
         w_sel  = ~w_diff[11] & (|w_diff);
         w_surv[b]   = w_sel;
         w_pm_new[b] = w_sel ? w_m1 : w_m0;
      end
   end

   // State register and step/word/address counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_len      <= 6'd0;
         r_step     <= 6'd0;
         r_word     <= 3'd0;
         r_sym_addr <= 6'd0;
         r_pt_din   <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len <= w_len;
                  if (w_len != 6'd0) begin
                     r_step     <= 6'd1;
                     r_word     <= 3'd0;
                     r_sym_addr <= 6'd0;
                  end
               end
            end
            S_ACS: begin
               r_pt_din <= w_surv;
               // Word counter parks on 7 after the final step so pt_addr holds
               if (r_word != 3'd7) begin
                  r_word <= r_word + 3'd1;
               end else if (r_step < r_len) begin
                  r_word     <= 3'd0;
                  r_step     <= r_step + 6'd1;
                  r_sym_addr <= r_step;
               end
            end
            default: ;
         endcase
      end
   end

   // Branch-metric register loaded while the symbol is on sym_dout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 8; c++) r_bm[c] <= 9'd0;
      end else if (r_state == S_BM) begin
         for (int c = 0; c < 8; c++) r_bm[c] <= w_bm[c];
      end
   end

   // Ping-pong path-metric banks: read r_bank, write the other, swap per step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bank <= 1'b0;
         for (int i = 0; i < 256; i++) begin
            r_pm[0][i] <= (i == 0) ? 12'd0 : C_PM_INIT;
            r_pm[1][i] <= (i == 0) ? 12'd0 : C_PM_INIT;
         end
      end else if (r_state == S_IDLE && start) begin
         r_bank <= 1'b0;
         for (int i = 0; i < 256; i++) begin
            r_pm[0][i] <= (i == 0) ? 12'd0 : C_PM_INIT;
         end
      end else if (r_state == S_ACS) begin
         for (int b = 0; b < 32; b++) begin
            r_pm[~r_bank][{r_word, 5'(b)}] <= w_pm_new[b];
         end
         if (r_word == 3'd7) r_bank <= ~r_bank;
      end
   end

endmodule
`default_nettype wire

// File: doc/vdec_hs_fwd.md
VDEC_HS_FWD -- requirements
Module: vdec_hs_fwd

Interface
REQ-001 clk  input  1  single clock for all logic, rising edge.
REQ-002 rst  input  1  reset, asynchronous and active-high; one clock, no other reset or clock.
REQ-003 start  input  1  one-cycle pulse; begins forward ACS of one code block; ignored while busy=1.
REQ-004 busy  output  1  high from cycle after accepted start through done cycle.
REQ-005 done  output  1  one-cycle pulse after last pointer word is written.
REQ-006 codeblk_size_p7  input  6  code block size plus 7; sampled on accepted start; trellis length L.
REQ-007 sym_rd  output  1  soft-symbol memory read strobe.
REQ-008 sym_addr  output  6  symbol address, one 3-LLR symbol per trellis step.
REQ-009 sym_dout  input  18  {llr2, llr1, llr0}, each 6-bit signed two's complement; valid cycle after sym_rd.
REQ-010 pt_wr  output  1  ptram write strobe.
REQ-011 pt_addr  output  9  ptram address {step[5:0], word[2:0]}.
REQ-012 pt_din  output  32  survivor bits; bit b of word w = survivor of state {w, b[4:0]}.

Function
REQ-013 Trellis: K=9, rate 1/3, 256 states; predecessors of state s are p0={0,s[7:1]}, p1={1,s[7:1]}; input bit u=s[0].
REQ-014 Branch window w[8:0]={p[7:0],u}; c0=^(w & 9'o557), c1=^(w & 9'o663), c2=^(w & 9'o711).
REQ-015 LLR convention: positive = coded bit 0; branch metric bm = sum over i of (ci ? -llri : +llri), 9-bit signed.
REQ-016 Eight branch metrics (one per {c2,c1,c0}) computed once per step and registered.
REQ-017 Path metrics: 12-bit, two banks of 256 (ping-pong: read old bank, write new bank, swap per step).
REQ-018 Candidate mj = pm[pj] + bm(pj->s), mod 4096; select p1 iff (m1 - m0) mod 4096 interpreted signed > 0; tie selects p0; survivor bit = selected predecessor MSB.
REQ-019 Initial metrics on accepted start: pm[0]=0, pm[1..255]=12'd3584.
REQ-020 L = codeblk_size_p7 clamped to 37 when > 37; L=0 performs no steps.
REQ-021 FSM states IDLE, RD, BM, ACS, FIN; IDLE->RD on start (L>0) or IDLE->FIN (L=0).
REQ-022 RD (1 cycle): sym_rd=1, sym_addr=k-1 for step k=1..L.
REQ-023 BM (1 cycle): latch sym_dout, register branch metrics.
REQ-024 ACS (8 cycles, word w=0..7): 32 ACS in parallel; pt_wr=1, pt_addr={k[5:0], w}, pt_din per REQ-012.
REQ-025 After word 7: k<L -> RD with k+1; k=L -> FIN.
REQ-026 FIN (1 cycle): done=1, busy=1; next cycle IDLE, busy=0.
REQ-027 Timing: start at cycle T -> step k occupies T+10(k-1)+1 .. T+10k; done at T+10L+1; 8L writes to rows 1..L, row 0 never written.
REQ-028 sym_rd, pt_wr, done zero outside their states; sym_addr, pt_addr, pt_din hold last value when idle.
REQ-029 start during busy (including FIN cycle) has no effect on any state or output.

Reset
REQ-030 rst asserted (any time, including mid-block): FSM to IDLE, busy, done, sym_rd, pt_wr to 0, sym_addr, pt_addr, pt_din to 0, step/word counters to 0, asynchronously.
REQ-031 Path metrics reset to init values of REQ-019; no ptram write in progress completes after rst.
REQ-032 After rst deasserts, next start begins a fresh block with no residue from the aborted one.

Verification
REQ-033 All-zero info, codeblk_size_p7=9, all LLRs +31 -> 72 writes to pt_addr 8..79, done at T+91, vdec_hs_bwd traceback returns dec_bits=0.
REQ-034 Random 29-bit info plus 8 zero tail, noiseless +-31 LLRs, codeblk_size_p7=37 -> done at T+371, vdec_hs_bwd dec_bits equals info bits.
REQ-035 All LLRs 0 -> every pt_din=32'h0 (tie rule), 8L writes.
REQ-036 start re-pulsed at T+5 and in FIN cycle -> ignored; single done at T+10L+1.
REQ-037 rst pulsed during step 5 ACS -> all outputs 0 immediately, no further writes; new start produces results identical to a clean run.
REQ-038 codeblk_size_p7=0 -> no sym_rd/pt_wr, done at T+1; codeblk_size_p7=50 -> behaves as 37, last pt_addr 303.
